// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div, HI/LO ownership, MDU stall.
// Optional madd/maddu/msub/msubu accumulate ops when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_Op,
  input  logic [31:0] E_RS_Data,
  input  logic [31:0] E_RT_Data,
  input  logic        D_MD_Use,
  output logic        Start,
  output logic        Busy,
  output logic        MDU_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDU_Out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_hi_n;
  logic [31:0]     r_lo_n;
  logic            r_wr;

  logic w_mul;
  logic w_div;
  logic w_sgn;
  logic w_mthi;
  logic w_mtlo;
`ifdef MDU_MADD_EN
  logic w_acc;
  logic w_sub;
`endif

  always_comb begin
    w_mul  = 1'b0;
    w_div  = 1'b0;
    w_sgn  = 1'b0;
    w_mthi = 1'b0;
    w_mtlo = 1'b0;
`ifdef MDU_MADD_EN
    w_acc  = 1'b0;
    w_sub  = 1'b0;
`endif
    case (E_MDU_Op)
      4'd1: begin w_mul = 1'b1; w_sgn = 1'b1; end
      4'd2: w_mul = 1'b1;
      4'd3: begin w_div = 1'b1; w_sgn = 1'b1; end
      4'd4: w_div = 1'b1;
      4'd5: w_mthi = 1'b1;
      4'd6: w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'd9:  begin w_mul = 1'b1; w_sgn = 1'b1; w_acc = 1'b1; end
      4'd10: begin w_mul = 1'b1; w_acc = 1'b1; end
      4'd11: begin
        w_mul = 1'b1; w_sgn = 1'b1; w_acc = 1'b1; w_sub = 1'b1;
      end
      4'd12: begin w_mul = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign Busy      = (r_state == S_RUN);
  assign Start     = (w_mul | w_div) & ~Busy;
  assign MDU_Stall = D_MD_Use & (Start | Busy);
  assign E_MDU_Out = (E_MDU_Op == 4'd7) ? HI :
                     (E_MDU_Op == 4'd8) ? LO : 32'h0;

  // Sign-extending to 64 bits makes one unsigned multiply serve both.
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;
  assign w_ea   = {{32{w_sgn & E_RS_Data[31]}}, E_RS_Data};
  assign w_eb   = {{32{w_sgn & E_RT_Data[31]}}, E_RT_Data};
  assign w_prod = w_ea * w_eb;

  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0]        w_q;
  logic [31:0]        w_r;
  logic               w_ovf;
  logic               w_dz;
  assign w_sq  = $signed(E_RS_Data) / $signed(E_RT_Data);
  assign w_sr  = $signed(E_RS_Data) % $signed(E_RT_Data);
  assign w_ovf = w_sgn && (E_RS_Data == 32'h8000_0000)
                       && (E_RT_Data == 32'hFFFF_FFFF);
  assign w_dz  = (E_RT_Data == 32'h0);
  assign w_q   = w_ovf ? 32'h8000_0000 :
                 w_sgn ? $unsigned(w_sq) : E_RS_Data / E_RT_Data;
  assign w_r   = w_ovf ? 32'h0 :
                 w_sgn ? $unsigned(w_sr) : E_RS_Data % E_RT_Data;

  logic [63:0] w_res;
`ifdef MDU_MADD_EN
  assign w_res = w_div ? {w_r, w_q} :
                 !w_acc ? w_prod :
                 w_sub ? ({HI, LO} - w_prod) : ({HI, LO} + w_prod);
`else
  assign w_res = w_div ? {w_r, w_q} : w_prod;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Start) w_next = S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi_n  <= '0;
      r_lo_n  <= '0;
      r_wr    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      r_state <= w_next;
      if (Start) begin
        {r_hi_n, r_lo_n} <= w_res;
        r_wr  <= ~(w_div & w_dz);
        r_cnt <= w_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (Busy) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1) && r_wr) begin
          HI <= r_hi_n;
          LO <= r_lo_n;
        end
      end else begin
        if (w_mthi) HI <= E_RS_Data;
        if (w_mtlo) LO <= E_RS_Data;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed literal cases plus random ops
// checked every cycle against a cycle-count/arithmetic model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        duse;
  logic        Start;
  logic        Busy;
  logic        MDU_Stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDU_Out;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDU_Op(op),
    .E_RS_Data(rs), .E_RT_Data(rt), .D_MD_Use(duse),
    .Start(Start), .Busy(Busy), .MDU_Stall(MDU_Stall),
    .HI(HI), .LO(LO), .E_MDU_Out(E_MDU_Out)
  );

  int checks = 0;
  int errors = 0;

  // Model: busy cycles left, architectural regs, pending result.
  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] p_res;
  bit          p_wr;

  function automatic bit is_start(logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit          e_busy;
    bit          e_start;
    logic [31:0] e_out;
    e_busy  = (m_left != 0);
    e_start = is_start(op) && !e_busy;
    e_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
    chk("busy", {31'b0, Busy}, {31'b0, e_busy});
    chk("start", {31'b0, Start}, {31'b0, e_start});
    chk("stall", {31'b0, MDU_Stall}, {31'b0, duse & (e_start | e_busy)});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    chk("out", E_MDU_Out, e_out);
  endtask

  task automatic model_step();
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = $signed(rs);
    sb = $signed(rt);
    ua = {32'b0, rs};
    ub = {32'b0, rt};
    if (reset) begin
      m_left = 0; m_hi = 0; m_lo = 0; p_res = 0; p_wr = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0 && p_wr) {m_hi, m_lo} = p_res;
    end else begin
      case (op)
        4'd1: begin p_res = sa * sb; p_wr = 1; m_left = MC; end
        4'd2: begin p_res = ua * ub; p_wr = 1; m_left = MC; end
        4'd3: begin
          m_left = DC;
          p_wr   = (rt != 0);
          if (p_wr) begin
            sq = sa / sb; sr = sa % sb;
            p_res = {sr[31:0], sq[31:0]};
          end
        end
        4'd4: begin
          m_left = DC;
          p_wr   = (rt != 0);
          if (p_wr) p_res = {32'(ua % ub), 32'(ua / ub)};
        end
        4'd5: m_hi = rs;
        4'd6: m_lo = rs;
`ifdef MDU_MADD_EN
        4'd9:  begin p_res = {m_hi, m_lo} + 64'(sa * sb); p_wr = 1; m_left = MC; end
        4'd10: begin p_res = {m_hi, m_lo} + ua * ub; p_wr = 1; m_left = MC; end
        4'd11: begin p_res = {m_hi, m_lo} - 64'(sa * sb); p_wr = 1; m_left = MC; end
        4'd12: begin p_res = {m_hi, m_lo} - ua * ub; p_wr = 1; m_left = MC; end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic cyc(logic [3:0] o, logic [31:0] a, logic [31:0] b,
                     logic u, logic r);
    @(negedge clk);
    op = o; rs = a; rt = b; duse = u; reset = r;
    #1;
    compare();
    model_step();
  endtask

  // Runs until Busy drops; o/a are driven only while the model is busy.
  task automatic drain(logic [3:0] o, logic [31:0] a, logic u,
                       output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_left != 0) cyc(o, a, 32'h0, u, 1'b0);
      else cyc(4'd0, 32'h0, 32'h0, u, 1'b0);
      if (!Busy) break;
      nb++;
    end
    chk("drain_timeout", {31'b0, Busy}, 32'h0);
  endtask

  initial begin
    int nb;
    logic [31:0] rv;
    reset = 1; op = 0; rs = 0; rt = 0; duse = 0;
    m_left = 0; m_hi = 0; m_lo = 0; p_res = 0; p_wr = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    cyc(1, 32'hFFFF_FFFD, 32'd5, 1, 0);
    chk("mult_start", {31'b0, Start}, 32'h1);
    drain(0, 0, 1, nb);
    chk("mult_lat", nb, MC);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF1);

    cyc(2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    drain(0, 0, 0, nb);
    chk("multu_hi", HI, 32'h1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    cyc(3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    drain(0, 0, 0, nb);
    chk("div_lat", nb, DC);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    cyc(4, 32'd7, 32'd2, 0, 0);
    drain(0, 0, 0, nb);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    cyc(5, 32'h11, 0, 0, 0);
    cyc(6, 32'h22, 0, 0, 0);
    cyc(3, 32'd100, 32'd0, 0, 0);
    drain(3, 32'd50, 0, nb);
    chk("dz_lat", nb, DC);
    chk("dz_hi", HI, 32'h11);
    chk("dz_lo", LO, 32'h22);

    cyc(3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    drain(0, 0, 0, nb);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'h0);

    cyc(1, 32'd3, 32'd4, 1, 0);
    drain(5, 32'hABCD, 1, nb);
    chk("mthi_busy_hi", HI, 32'h0);
    chk("mthi_busy_lo", LO, 32'd12);

    cyc(1, 32'd7, 32'd9, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(8, 0, 0, 0, 0);
    chk("abort_busy", {31'b0, Busy}, 32'h0);
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_mflo", E_MDU_Out, 32'h0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rv = 32'h0;
        1: rv = 32'hFFFF_FFFF;
        2: rv = $urandom_range(1, 20);
        default: rv = $urandom;
      endcase
      cyc(4'($urandom_range(0, 15)), $urandom, rv,
          1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
    drain(0, 0, 0, nb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
